// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared definitions for the PSRAM two-port arbiter.
//   - FSM state encoding (3 bits) and its enum type
//   - port count and the address / length / data field widths
//   - small helpers converting between a grant index and a one-hot grant
package psram_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 12;
    localparam int DATA_W    = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARB       = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_XFER      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_FIN       = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        ARB       = ST_ARB,
        ISSUE     = ST_ISSUE,
        XFER      = ST_XFER,
        WAIT_DONE = ST_WAIT_DONE,
        FIN       = ST_FIN
    } arb_state_e;

    // Index of a one-hot two-port grant (bit 1 set -> port 1).
    function automatic logic onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        return oh[1];
    endfunction

    // One-hot vector for a grant index.
    function automatic logic [NUM_PORTS-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: client-side request/beat bus of the PSRAM arbiter.
//   req_valid/req_rw/req_addr/req_len/wr_data : client -> arbiter (packed per port)
//   req_ready/port_wr_valid/port_rd_valid/port_done/port_err : arbiter -> client
// Modports: master = client side, slave = arbiter side.
interface psram_arbiter_if;
    import psram_arb_pkg::*;

    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS-1:0]          req_rw;
    logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
    logic [NUM_PORTS*LEN_W-1:0]    req_len;
    logic [NUM_PORTS*DATA_W-1:0]   wr_data;
    logic [NUM_PORTS-1:0]          req_ready;
    logic [NUM_PORTS-1:0]          port_wr_valid;
    logic [NUM_PORTS-1:0]          port_rd_valid;
    logic [NUM_PORTS-1:0]          port_done;
    logic [NUM_PORTS-1:0]          port_err;

    modport master (
        output req_valid, req_rw, req_addr, req_len, wr_data,
        input  req_ready, port_wr_valid, port_rd_valid, port_done, port_err
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_len, wr_data,
        output req_ready, port_wr_valid, port_rd_valid, port_done, port_err
    );

endinterface

// File: rtl/psram_rr_pick.sv
// psram_rr_pick: combinational two-port round-robin picker.
//   req_i        : per-port request
//   last_grant_i : index of the port granted last
//   gnt_o        : one-hot grant (zero when nothing requests)
module psram_rr_pick
    import psram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 last_grant_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    // A tie goes to the port that did not win last time.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port round-robin front end for the PSRAM controller.
// Serialises client bursts onto the controller command interface, issues one
// psram_exe per transaction and steers per-beat strobes / write data to the
// granted client.
// Ports:
//   sys_clk, sys_rst (sync, active-high), init_cable_complete
//   bus        : client bus (psram_arbiter_if.slave)
//   psram_done, psram_wr_valid, psram_rd_valid : controller status in
//   psram_exe, rw_ctrl, addr_in, burst_len, data_in : controller command out
//   bit_ctrl, wrap_in, byte_write, command_in : constant controller settings
// Build option: PSRAM_ARB_WDOG_EN adds a stall watchdog (WDOG_CYCLES) that
// ends a stuck transfer with an error completion.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int BIT_MODE    = 16,
    parameter     WRAP_MODE   = "wrap",
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                init_cable_complete,
    psram_arbiter_if.slave      bus,
    input  logic                psram_done,
    input  logic                psram_wr_valid,
    input  logic                psram_rd_valid,
    output logic                psram_exe,
    output logic                rw_ctrl,
    output logic [ADDR_W-1:0]   addr_in,
    output logic [LEN_W-1:0]    burst_len,
    output logic [DATA_W-1:0]   data_in,
    output logic                bit_ctrl,
    output logic                wrap_in,
    output logic [1:0]          byte_write,
    output logic [1:0]          command_in
);

    arb_state_e              state_q;
    logic                    gnt_q;
    logic                    last_q;
    logic                    rw_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt_q;
    logic                    exe_q;
    logic [NUM_PORTS-1:0]    ready_q;
    logic [NUM_PORTS-1:0]    done_q;
    logic [NUM_PORTS-1:0]    err_q;

    logic [NUM_PORTS-1:0]    pick_s;
    logic                    pick_idx_s;
    logic                    pick_rw_s;
    logic [ADDR_W-1:0]       pick_addr_s;
    logic [LEN_W-1:0]        pick_len_s;
    logic [NUM_PORTS-1:0]    gnt_oh_s;
    logic [LEN_W-1:0]        cnt_inc_s;
    logic                    beat_s;
    logic                    wd_hit_s;
    logic [NUM_PORTS-1:0]    wr_strobe_s;
    logic [NUM_PORTS-1:0]    rd_strobe_s;
    logic [DATA_W-1:0]       data_s;

    psram_rr_pick u_pick (
        .req_i        (bus.req_valid),
        .last_grant_i (last_q),
        .gnt_o        (pick_s)
    );

    assign pick_idx_s = onehot_to_idx(pick_s);
    assign gnt_oh_s   = idx_to_onehot(gnt_q);
    assign cnt_inc_s  = cnt_q + 12'd1;
    // Only beats of the granted direction count; the other strobe is ignored.
    assign beat_s     = (state_q == XFER) && (rw_q ? psram_wr_valid : psram_rd_valid);

    // Request fields of the port the picker selected.
    always_comb begin
        pick_rw_s   = 1'b0;
        pick_addr_s = 32'h0000_0000;
        pick_len_s  = 12'd0;
        case (pick_idx_s)
            1'b0: begin
                pick_rw_s   = bus.req_rw[0];
                pick_addr_s = bus.req_addr[31:0];
                pick_len_s  = bus.req_len[11:0];
            end
            default: begin
                pick_rw_s   = bus.req_rw[1];
                pick_addr_s = bus.req_addr[63:32];
                pick_len_s  = bus.req_len[23:12];
            end
        endcase
    end

    // Zero-latency beat strobe and write data routing to the granted port.
    always_comb begin
        wr_strobe_s = 2'b00;
        rd_strobe_s = 2'b00;
        data_s      = 16'h0000;
        if (state_q == XFER) begin
            if (rw_q) begin
                wr_strobe_s[gnt_q] = psram_wr_valid;
            end else begin
                rd_strobe_s[gnt_q] = psram_rd_valid;
            end
        end else begin
            wr_strobe_s = 2'b00;
        end
        if (rw_q && (state_q == ISSUE || state_q == XFER || state_q == WAIT_DONE)) begin
            data_s = gnt_q ? bus.wr_data[31:16] : bus.wr_data[15:0];
        end else begin
            data_s = 16'h0000;
        end
    end

`ifdef PSRAM_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    // Stall counter: runs in XFER/WAIT_DONE, cleared by routed beats. The
    // XFER->WAIT_DONE move always coincides with the final beat, so the
    // state change clears it as well.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wd_q <= '0;
        end else if (beat_s || (state_q != XFER && state_q != WAIT_DONE)) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_hit_s = (wd_q == WD_W'(WDOG_CYCLES - 1));
`else
    // No watchdog: the stall condition can never be met.
    assign wd_hit_s = (WDOG_CYCLES < 0);
`endif

    // Arbitration FSM with registered command and completion outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            len_q   <= 12'd0;
            cnt_q   <= 12'd0;
            exe_q   <= 1'b0;
            ready_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            exe_q   <= 1'b0;
            ready_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (init_cable_complete) state_q <= ARB;
                    else                     state_q <= IDLE;
                end
                ARB: begin
                    // Command fields are latched here so they are already
                    // valid in the ISSUE cycle alongside psram_exe.
                    if (init_cable_complete && (pick_s != 2'b00)) begin
                        gnt_q   <= pick_idx_s;
                        last_q  <= pick_idx_s;
                        rw_q    <= pick_rw_s;
                        addr_q  <= pick_addr_s;
                        len_q   <= pick_len_s;
                        cnt_q   <= 12'd0;
                        ready_q <= pick_s;
                        exe_q   <= (pick_len_s != 12'd0);
                        state_q <= ISSUE;
                    end else begin
                        state_q <= ARB;
                    end
                end
                ISSUE: begin
                    if (len_q == 12'd0) begin
                        done_q  <= gnt_oh_s;
                        state_q <= FIN;
                    end else begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (beat_s) cnt_q <= cnt_inc_s;
                    if (beat_s && (cnt_inc_s == len_q)) begin
                        if (psram_done) begin
                            done_q  <= gnt_oh_s;
                            state_q <= FIN;
                        end else begin
                            state_q <= WAIT_DONE;
                        end
                    end else if (psram_done || wd_hit_s) begin
                        done_q  <= gnt_oh_s;
                        err_q   <= gnt_oh_s;
                        state_q <= FIN;
                    end else begin
                        state_q <= XFER;
                    end
                end
                WAIT_DONE: begin
                    if (psram_done) begin
                        done_q  <= gnt_oh_s;
                        state_q <= FIN;
                    end else if (wd_hit_s) begin
                        done_q  <= gnt_oh_s;
                        err_q   <= gnt_oh_s;
                        state_q <= FIN;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                FIN:     state_q <= ARB;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.port_done     = done_q;
    assign bus.port_err      = err_q;
    assign bus.port_wr_valid = wr_strobe_s;
    assign bus.port_rd_valid = rd_strobe_s;
    assign psram_exe         = exe_q;
    assign rw_ctrl           = rw_q;
    assign addr_in           = addr_q;
    assign burst_len         = len_q;
    assign data_in           = data_s;
    assign bit_ctrl          = (BIT_MODE == 16) ? 1'b1 : 1'b0;
    assign wrap_in           = (WRAP_MODE == "wrap") ? 1'b0 : 1'b1;
    assign byte_write        = 2'b00;
    assign command_in        = 2'b00;

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Two-port round-robin arbiter in front of the PSRAM controller. Lets two independent clients (e.g. a video write path and a readback path) share the controller's single command interface. It serializes their burst requests, issues one `psram_exe` per transaction, and steers the controller's per-beat `psram_wr_valid`/`psram_rd_valid` strobes and write data to the granted client. It replaces any fixed write-then-read sequencer placed between init logic and the controller.

## Interface
Parameters:
- `BIT_MODE`, 16 — 16 drives `bit_ctrl`=1, otherwise 0.
- `WRAP_MODE`, "wrap" — "wrap" drives `wrap_in`=0, otherwise 1.
- `WDOG_CYCLES`, 1024 — stall limit, used only with `PSRAM_ARB_WDOG_EN`.

Ports (single clock `sys_clk`; reset `sys_rst` is synchronous, active-high):
- `sys_clk` in 1 — clock.
- `sys_rst` in 1 — synchronous active-high reset.
- `init_cable_complete` in 1 — controller calibrated; level signal.
- `req_valid` in 2 — per-port request, held until accepted.
- `req_rw` in 2 — per-port direction, 1=write.
- `req_addr` in 64 — port i at [32i+31:32i].
- `req_len` in 24 — port i beats at [12i+11:12i].
- `wr_data` in 32 — port i write word at [16i+15:16i].
- `req_ready` out 2 — one-cycle accept pulse.
- `port_wr_valid` out 2 — write-beat strobe, granted port only.
- `port_rd_valid` out 2 — read-beat strobe, granted port only.
- `port_done` out 2 — one-cycle completion pulse.
- `port_err` out 2 — qualifies `port_done`; 1 = short or aborted burst.
- `psram_done` in 1 — controller one-cycle end-of-burst pulse.
- `psram_wr_valid` in 1 — controller consumed `data_in`.
- `psram_rd_valid` in 1 — controller read beat valid.
- `psram_exe` out 1 — one-cycle command pulse.
- `rw_ctrl` out 1 — 1=write.
- `addr_in` out 32 — burst address.
- `burst_len` out 12 — burst length.
- `data_in` out 16 — write data.
- `bit_ctrl` out 1, `wrap_in` out 1, `byte_write` out 2 (=2'b00), `command_in` out 2 (=2'b00) — constants.

## Operation
- States: IDLE, ARB, ISSUE, XFER, WAIT_DONE, FIN.
- IDLE → ARB when `init_cable_complete`=1.
- ARB: no request → stay in ARB.
  - One request → grant it.
  - Both requesting → grant the port not in `last_grant`. `last_grant` resets to 1, so port 0 wins the first tie.
  - Grant is registered; go to ISSUE.
- ISSUE (1 cycle): `req_ready[g]`=1 and `psram_exe`=1. Latch `rw_ctrl`, `addr_in`, `burst_len` from port g. Clear the beat counter. Update `last_grant`=g.
  - `req_len`=0 → skip the controller: no `psram_exe`, go to FIN with err=0.
  - Otherwise → XFER.
- XFER: increment the 12-bit counter on `psram_wr_valid` (write) or `psram_rd_valid` (read).
  - Counter reaches `burst_len` → WAIT_DONE.
  - `psram_done` arrives first → FIN with err=1.
  - The strobe of the wrong direction is ignored.
- WAIT_DONE: `psram_done` → FIN with err=0. Extra beats are ignored.
- FIN (1 cycle): `port_done[g]`=1 and `port_err[g]`=err. → ARB.
- `init_cable_complete` falling outside IDLE does not abort the current transaction. ARB holds until it is 1 again.
- Strobe routing is combinational and zero-latency:
  - `port_wr_valid[g]` = `psram_wr_valid` & XFER & write.
  - `port_rd_valid[g]` = `psram_rd_valid` & XFER & read.
  - Non-granted bits are 0.
- `data_in` = `wr_data[g]` while a write is granted, else 0.

## Timing
- Reset values: all outputs 0 except the constants; state IDLE; `last_grant`=1.
- Request-to-`psram_exe` latency is 2 cycles (ARB, then ISSUE) when the arbiter is idle in ARB.
- `addr_in`, `burst_len`, `rw_ctrl` are stable from ISSUE until the next ISSUE.
- Back-to-back transactions: FIN → ARB → ISSUE, so 3 cycles from `psram_done` to the next `psram_exe`.
- The requester must hold `req_*` until `req_ready`. `req_valid` dropped before accept is legal; the grant then evaporates in ARB only, never in ISSUE.
- `sys_rst` mid-burst returns to IDLE on the next edge with no `port_done`. The controller must be reset by the same `sys_rst`.

## Configuration
- `PSRAM_ARB_WDOG_EN` defined: a stall counter runs in XFER and WAIT_DONE.
  - It clears on every routed beat or state change.
  - When it reaches `WDOG_CYCLES`, go to FIN with err=1.
- `PSRAM_ARB_WDOG_EN` not defined: no counter. XFER and WAIT_DONE wait indefinitely.

## Structure
- Shared package `psram_arb_pkg` holds:
  - the state encoding localparams (3 bits);
  - port count 2;
  - field widths ADDR_W=32, LEN_W=12, DATA_W=16.
- One sub-module, `psram_rr_pick`: 2-bit request plus `last_grant` in, one-hot grant out, combinational.

## Test plan
- Port 0 write, len 32, addr 0x100:
  - `psram_exe` is a single pulse with `rw_ctrl`=1, `addr_in`=0x100, `burst_len`=32;
  - 32 `port_wr_valid[0]` strobes;
  - `port_done[0]`=1 with `port_err`=0 one cycle after `psram_done`.
- Both ports request continuously: grants alternate 0,1,0,1, and there are never two `psram_exe` pulses without an intervening `psram_done`.
- Port 1 read, len 8; controller raises `psram_done` after 5 beats: `port_done[1]`=1 with `port_err[1]`=1, and only 5 `port_rd_valid[1]`.
- Port 0 request with len 0: `req_ready[0]` and `port_done[0]` are asserted, and no `psram_exe` is issued.
- `sys_rst` pulsed during XFER beat 10 of 32: outputs return to reset values next cycle and no `port_done` is produced.
- With `PSRAM_ARB_WDOG_EN` and `WDOG_CYCLES`=16, stop controller strobes mid-burst: `port_err`=1 exactly 16 cycles after the last beat.
